// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - shared CP0 exception codes, sequencer state encodings and interrupt helper
package exc_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_REDIR  = 2'd3;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  typedef struct packed {
    logic fetch_adel;
    logic ri;
    logic ov;
    logic sys;
    logic bp;
    logic data_adel;
    logic data_ades;
  } exc_flags_t;

  // Timer interrupt shares IP7 with hardware line 5; IP1:0 are the software bits in Cause.
  function automatic logic int_pending(
    input logic       ie,
    input logic       exl,
    input logic [7:0] im,
    input logic [5:0] hw_int,
    input logic       timer,
    input logic [1:0] sw_int
  );
    return ie & ~exl & (|(im & {hw_int[5] | timer, hw_int[4:0], sw_int}));
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority exception encoder (interrupt above all MEM-stage faults)
import exc_ctrl_pkg::*;

module exc_prio_enc (
  input  exc_flags_t  flags,
  input  logic        int_pend,
  output logic        valid,
  output logic [4:0]  exccode,
  output logic        bad_we,
  output logic        fetch_fault
);

  always_comb begin
    valid       = 1'b1;
    exccode     = EXC_INT;
    bad_we      = 1'b0;
    fetch_fault = 1'b0;
    if (int_pend) begin
      exccode = EXC_INT;
    end else if (flags.fetch_adel) begin
      exccode     = EXC_ADEL;
      bad_we      = 1'b1;
      fetch_fault = 1'b1;
    end else if (flags.ri) begin
      exccode = EXC_RI;
    end else if (flags.ov) begin
      exccode = EXC_OV;
    end else if (flags.sys) begin
      exccode = EXC_SYS;
    end else if (flags.bp) begin
      exccode = EXC_BP;
    end else if (flags.data_adel) begin
      exccode = EXC_ADEL;
      bad_we  = 1'b1;
    end else if (flags.data_ades) begin
      exccode = EXC_ADES;
      bad_we  = 1'b1;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/ERET sequencer: CP0 commit, pipeline flush, fetch redirect
import exc_ctrl_pkg::*;

module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT,
  parameter int          REDIR_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [6:0]  exc_flags_i,
  input  logic        eret_i,
  input  logic        delayslot_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badaddr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_exccode_o,
  output logic [31:0] cp0_epc_o,
  output logic        cp0_bd_o,
  output logic [31:0] cp0_badvaddr_o,
  output logic        cp0_bad_we_o,
  output logic        cp0_eret_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redir_valid_o,
  output logic [31:0] redir_pc_o,
  input  logic        redir_ready_i,
  output logic        busy_o,
  output logic        timeout_o
);

  logic [1:0]  state;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] badvaddr_q;
  logic        bad_we_q;
  logic        eret_q;
  logic [31:0] target_q;
  logic [3:0]  cnt_q;
  logic        timeout_q;

  logic        int_pend;
  logic        enc_valid;
  logic [4:0]  enc_code;
  logic        enc_bad_we;
  logic        enc_fetch;
  logic        is_idle;
  logic        in_commit;
  logic        in_redir;
  logic        take_exc;
  logic        take_eret;
  logic        redir_expire;
  logic [3:0]  cnt_sat;

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

  assign int_pend = int_pending(status_i[0], status_i[1], status_i[15:8],
                                int_i, timer_int_i, cause_i[9:8]);

  exc_prio_enc u_prio (
    .flags       (exc_flags_t'(exc_flags_i)),
    .int_pend    (int_pend),
    .valid       (enc_valid),
    .exccode     (enc_code),
    .bad_we      (enc_bad_we),
    .fetch_fault (enc_fetch)
  );

  assign is_idle   = (state == ST_IDLE);
  assign in_commit = (state == ST_COMMIT);
  assign in_redir  = (state == ST_REDIR);

  // Gated by rst so the Mealy ERET strobe stays quiet while reset is held.
  assign take_exc  = rst & is_idle & mem_valid_i & enc_valid;
  assign take_eret = rst & is_idle & mem_valid_i & ~enc_valid & eret_i;

  assign cnt_sat      = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign redir_expire = in_redir & ~redir_ready_i & ((int'(cnt_q) + 1) >= REDIR_TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      code_q     <= 5'd0;
      pc_q       <= 32'd0;
      bd_q       <= 1'b0;
      badvaddr_q <= 32'd0;
      bad_we_q   <= 1'b0;
      eret_q     <= 1'b0;
      target_q   <= 32'd0;
      cnt_q      <= 4'd0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_exc) begin
            state      <= ST_COMMIT;
            code_q     <= enc_code;
            pc_q       <= pc_i;
            bd_q       <= delayslot_i;
            badvaddr_q <= enc_fetch ? pc_i : badaddr_i;
            bad_we_q   <= enc_bad_we;
            eret_q     <= 1'b0;
          end else if (take_eret) begin
            state    <= ST_FLUSH;
            target_q <= epc_i;
            eret_q   <= 1'b1;
          end
        end
        ST_COMMIT: state <= ST_FLUSH;
        ST_FLUSH: begin
          state <= ST_REDIR;
          cnt_q <= 4'd0;
        end
        default: begin
          if (redir_ready_i) begin
            state <= ST_IDLE;
            cnt_q <= 4'd0;
          end else if (redir_expire) begin
            state     <= ST_IDLE;
            cnt_q     <= 4'd0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_sat;
          end
        end
      endcase
    end
  end

  // Payload is driven even with EXL set; CP0 decides whether EPC/BD are updated.
  assign cp0_we_o       = in_commit;
  assign cp0_exccode_o  = in_commit ? code_q : 5'd0;
  assign cp0_epc_o      = in_commit ? (bd_q ? pc_q - 32'd4 : pc_q) : 32'd0;
  assign cp0_bd_o       = in_commit & bd_q;
  assign cp0_badvaddr_o = in_commit ? badvaddr_q : 32'd0;
  assign cp0_bad_we_o   = in_commit & bad_we_q;
  assign cp0_eret_o     = take_eret;
  assign flush_o        = (state == ST_FLUSH);
  assign stall_o        = ~is_idle;
  assign busy_o         = ~is_idle;
  assign redir_valid_o  = in_redir;
  assign redir_pc_o     = in_redir ? (eret_q ? target_q : EXC_VECTOR) : 32'd0;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - randomized and directed bench for exc_ctrl against a transaction-level model
module tb_exc_ctrl;

  localparam int K_NONE = 0;
  localparam int K_EXC  = 1;
  localparam int K_ERET = 2;
  localparam int TMO    = 15;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [6:0]  flags;
  logic        eret;
  logic        delayslot;
  logic [31:0] pc;
  logic [31:0] badaddr;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [5:0]  int_in;
  logic        timer;
  logic        redir_ready;

  logic        cp0_we;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_epc;
  logic        cp0_bd;
  logic [31:0] cp0_badvaddr;
  logic        cp0_bad_we;
  logic        cp0_eret;
  logic        flush;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        busy;
  logic        timeout;

  int   vectors    = 0;
  int   miscompares = 0;
  logic exp_timeout = 1'b0;

  // Exception code per flag bit, bit 0 = data_ades ... bit 6 = fetch_adel.
  logic [4:0] flag_code [7] = '{5'd5, 5'd4, 5'd9, 5'd8, 5'd12, 5'd10, 5'd4};

  exc_ctrl dut (
    .clk            (clk),
    .rst            (rst_n),
    .mem_valid_i    (mem_valid),
    .exc_flags_i    (flags),
    .eret_i         (eret),
    .delayslot_i    (delayslot),
    .pc_i           (pc),
    .badaddr_i      (badaddr),
    .status_i       (status),
    .cause_i        (cause),
    .epc_i          (epc),
    .int_i          (int_in),
    .timer_int_i    (timer),
    .cp0_we_o       (cp0_we),
    .cp0_exccode_o  (cp0_exccode),
    .cp0_epc_o      (cp0_epc),
    .cp0_bd_o       (cp0_bd),
    .cp0_badvaddr_o (cp0_badvaddr),
    .cp0_bad_we_o   (cp0_bad_we),
    .cp0_eret_o     (cp0_eret),
    .flush_o        (flush),
    .stall_o        (stall),
    .redir_valid_o  (redir_valid),
    .redir_pc_o     (redir_pc),
    .redir_ready_i  (redir_ready),
    .busy_o         (busy),
    .timeout_o      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic quiet();
    mem_valid = 1'b0; flags = 7'd0; eret = 1'b0; delayslot = 1'b0;
    pc = 32'd0; badaddr = 32'd0; status = 32'd0; cause = 32'd0; epc = 32'd0;
    int_in = 6'd0; timer = 1'b0; redir_ready = 1'b0;
  endtask

  task automatic noise();
    mem_valid = 1'($urandom); flags = 7'($urandom); eret = 1'($urandom);
    delayslot = 1'($urandom); pc = $urandom; badaddr = $urandom;
    status = $urandom | 32'h0000FF01; cause = $urandom; epc = $urandom;
    int_in = 6'($urandom); timer = 1'($urandom);
  endtask

  task automatic classify(output int kind, output logic [4:0] code);
    logic [7:0] lines;
    lines = {int_in[5] | timer, int_in[4:0], cause[9:8]};
    kind = K_NONE;
    code = 5'd0;
    if (mem_valid) begin
      if (status[0] && !status[1] && ((status[15:8] & lines) != 8'd0)) begin
        kind = K_EXC;
      end else begin
        for (int b = 6; b >= 0; b--) begin
          if (kind == K_NONE && flags[b]) begin
            kind = K_EXC;
            code = flag_code[b];
          end
        end
        if (kind == K_NONE && eret) kind = K_ERET;
      end
    end
  endtask

  // Inputs for the IDLE cycle are already applied; returns just after a posedge with the DUT idle.
  task automatic run_txn(input bit hold_ready_low);
    int          kind;
    int          unaccepted;
    logic [4:0]  code;
    logic [31:0] e_epc;
    logic [31:0] e_bva;
    logic [31:0] e_redir;
    logic        e_bd;
    logic        e_bad_we;
    logic        accepted;
    classify(kind, code);
    e_epc    = delayslot ? pc - 32'd4 : pc;
    e_bd     = delayslot;
    e_bad_we = (kind == K_EXC) && (code == 5'd4 || code == 5'd5);
    e_bva    = flags[6] ? pc : badaddr;
    e_redir  = (kind == K_ERET) ? epc : VEC;

    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_eret", cp0_eret, kind == K_ERET);
    check_eq("idle_we", cp0_we, 0);
    check_eq("timeout", timeout, exp_timeout);
    @(posedge clk); #1; noise();
    if (kind == K_NONE) return;

    if (kind == K_EXC) begin
      @(negedge clk);
      check_eq("commit_we", cp0_we, 1);
      check_eq("commit_code", cp0_exccode, code);
      check_eq("commit_epc", cp0_epc, e_epc);
      check_eq("commit_bd", cp0_bd, e_bd);
      check_eq("commit_bad_we", cp0_bad_we, e_bad_we);
      if (e_bad_we) check_eq("commit_badvaddr", cp0_badvaddr, e_bva);
      check_eq("commit_flush", flush, 0);
      check_eq("commit_stall", stall, 1);
      @(posedge clk); #1; noise();
    end

    @(negedge clk);
    check_eq("flush", flush, 1);
    check_eq("flush_we", cp0_we, 0);
    check_eq("flush_stall", stall, 1);
    check_eq("flush_redir", redir_valid, 0);
    @(posedge clk); #1; noise();

    unaccepted = 0;
    for (int c = 0; c < TMO + 4; c++) begin
      redir_ready = hold_ready_low ? 1'b0 : ($urandom_range(0, 3) == 0);
      @(negedge clk);
      check_eq("redir_valid", redir_valid, 1);
      check_eq("redir_pc", redir_pc, e_redir);
      check_eq("redir_stall", stall, 1);
      check_eq("redir_eret", cp0_eret, 0);
      accepted = redir_ready;
      @(posedge clk); #1; noise(); redir_ready = 1'b0;
      if (accepted) break;
      unaccepted++;
      if (unaccepted == TMO) begin
        exp_timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we"}, cp0_we, 0);
    check_eq({tag, "_epc"}, cp0_epc, 0);
    check_eq({tag, "_eret"}, cp0_eret, 0);
    check_eq({tag, "_flush"}, flush, 0);
    check_eq({tag, "_stall"}, stall, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_redir"}, redir_valid, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    quiet();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    quiet(); mem_valid = 1; flags = 7'b0010000; pc = 32'h80001000;
    run_txn(0);
    quiet(); mem_valid = 1; flags = 7'b0001000; pc = 32'h80002004; delayslot = 1;
    run_txn(0);
    quiet(); mem_valid = 1; flags = 7'b0010001; badaddr = 32'h00000003; pc = 32'h80001100;
    run_txn(0);
    quiet(); mem_valid = 1; flags = 7'b0100000; status = 32'h0000FF01; timer = 1; pc = 32'h80004000;
    run_txn(0);
    quiet(); mem_valid = 1; status = 32'h0000FF03; timer = 1; pc = 32'h80004004;
    run_txn(0);
    quiet(); mem_valid = 1; flags = 7'b1000010; badaddr = 32'h1234; pc = 32'h80005001;
    run_txn(0);
    quiet(); mem_valid = 1; eret = 1; epc = 32'h80003000;
    run_txn(0);
    quiet(); mem_valid = 1; flags = 7'b0010000; pc = 32'h80006000;
    run_txn(1);

    quiet(); mem_valid = 1; flags = 7'b0010000; pc = 32'h80007000;
    @(posedge clk); #1; quiet();
    #2;
    check_eq("pre_reset_we", cp0_we, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_timeout = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("post_reset");
    @(posedge clk); #1;

    for (int t = 0; t < 150; t++) begin
      quiet();
      mem_valid = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < 7; b++) flags[b] = ($urandom_range(0, 9) == 0);
      eret      = ($urandom_range(0, 2) == 0);
      delayslot = 1'($urandom);
      pc        = $urandom;
      badaddr   = $urandom;
      epc       = $urandom;
      cause     = $urandom;
      status    = $urandom;
      status[0] = ($urandom_range(0, 3) != 0);
      status[1] = ($urandom_range(0, 3) == 0);
      int_in    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      timer     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) cause[9:8] = 2'b00;
      run_txn(0);
    end

    quiet();
    @(negedge clk);
    check_eq("final_busy", busy, 0);
    check_eq("final_timeout", timeout, exp_timeout);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
